sseg_display_arbiter: RTL and testbench

Shares the board's four 7-segment digits and eight LEDs between two requesters (A: Nios PIO-driven status, B: hardware counter/monitor) under control of the two slide switches. Sits between the requesters and the top-level `sseg0..3`/`led` pins, replacing direct PIO-to-pin wiring. Provides switch debounce, a round-robin arbiter with minimum dwell time, hex-to-segment decode, and lamp test.

---
 rtl/sseg_pkg.sv | 48 ++++
 rtl/sseg_display_arbiter_if.sv | 31 +++
 rtl/sseg_display_arbiter_hex_to_sseg.sv | 13 +
 rtl/sseg_display_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sseg_display_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the 7-segment display arbiter:
// switch modes, arbiter states, active-low blank/lamp patterns and hex decode.
package sseg_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO    = 2'b00,
        MODE_FORCE_A = 2'b01,
        MODE_FORCE_B = 2'b10,
        MODE_LAMP    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_A = 2'b01,
        ST_GNT_B = 2'b10,
        ST_LAMP  = 2'b11
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_LAMP  = 8'h00;
    localparam logic [7:0] LED_OFF   = 8'h00;
    localparam logic [7:0] LED_LAMP  = 8'hFF;

    // Active-low segment pattern, bit order g..a.
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sseg_display_arbiter_if.sv
// Requester-side and pin-side signals of the display arbiter, grouped so the
// arbiter and its environment share one bundle.
interface sseg_display_arbiter_if;

    logic        req_a;
    logic        req_b;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic [3:0]  dp_a;
    logic [3:0]  dp_b;
    logic [7:0]  led_a;
    logic [7:0]  led_b;
    logic        grant_a;
    logic        grant_b;
    logic [7:0]  sseg0;
    logic [7:0]  sseg1;
    logic [7:0]  sseg2;
    logic [7:0]  sseg3;
    logic [7:0]  led_out;

    modport master (
        output req_a, req_b, data_a, data_b, dp_a, dp_b, led_a, led_b,
        input  grant_a, grant_b, sseg0, sseg1, sseg2, sseg3, led_out
    );

    modport slave (
        input  req_a, req_b, data_a, data_b, dp_a, dp_b, led_a, led_b,
        output grant_a, grant_b, sseg0, sseg1, sseg2, sseg3, led_out
    );

endinterface

// File: rtl/sseg_display_arbiter_hex_to_sseg.sv
// One digit of hex-to-segment decode: nibble plus active-high dp in,
// active-low {dp, g..a} out.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {~dp, hex_to_seg7(nibble)};

endmodule

// File: rtl/sseg_display_arbiter.sv
// Arbitrates the four 7-segment digits and eight LEDs between two requesters,
// with debounced mode switches, round-robin plus minimum dwell, and lamp test.
module sseg_display_arbiter
    import sseg_pkg::*;
#(
    parameter int DWELL_CYCLES    = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [1:0]            switch_in,
    sseg_display_arbiter_if.slave bus
);

    localparam int DW_W = $clog2(DWELL_CYCLES + 1);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DWELL_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sw_meta;
    logic [1:0]      sw_sync;
    logic [1:0]      sw_cand;
    logic [DB_W-1:0] db_cnt;
    mode_e           mode;
    mode_e           mode_prev;
    logic            mode_change;

    state_e          state;
    state_e          state_next;
    logic [DW_W-1:0] dwell;
    logic            dwell_done;
    logic            a_first;
    logic            entry_a;
    logic            entry_b;

    logic [15:0]     sel_data;
    logic [3:0]      sel_dp;
    logic [7:0]      sel_led;
    logic [7:0]      seg_dec [4];
    logic [7:0]      sseg_p2 [4];
    logic [7:0]      led_p2;

    // Stage: switch synchronizer and debouncer. A candidate value must be seen
    // for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sw_meta   <= 2'b00;
            sw_sync   <= 2'b00;
            sw_cand   <= 2'b00;
            db_cnt    <= '0;
            mode      <= MODE_AUTO;
            mode_prev <= MODE_AUTO;
        end else begin
            sw_meta   <= switch_in;
            sw_sync   <= sw_meta;
            mode_prev <= mode;
            if (sw_sync == mode) begin
                sw_cand <= sw_sync;
                db_cnt  <= '0;
            end else if (sw_sync != sw_cand) begin
                sw_cand <= sw_sync;
                db_cnt  <= DB_W'(1);
            end else if (db_cnt >= DB_LAST) begin
                mode    <= mode_e'(sw_sync);
                db_cnt  <= '0;
            end else begin
                db_cnt  <= db_cnt + DB_W'(1);
            end
        end
    end

    assign mode_change = (mode != mode_prev);
    assign dwell_done  = (dwell >= DWELL_MAX);

    // Stage: arbiter next-state. A freshly changed mode always costs one IDLE cycle.
    always_comb begin
        state_next = state;
        if (mode_change) begin
            state_next = ST_IDLE;
        end else begin
            case (mode)
                MODE_AUTO: begin
                    case (state)
                        ST_GNT_A: begin
                            if (!bus.req_a)
                                state_next = ST_IDLE;
                            else if (bus.req_b && dwell_done)
                                state_next = ST_GNT_B;
                            else
                                state_next = ST_GNT_A;
                        end
                        ST_GNT_B: begin
                            if (!bus.req_b)
                                state_next = ST_IDLE;
                            else if (bus.req_a && dwell_done)
                                state_next = ST_GNT_A;
                            else
                                state_next = ST_GNT_B;
                        end
                        default: begin
                            if (bus.req_a && bus.req_b)
                                state_next = a_first ? ST_GNT_A : ST_GNT_B;
                            else if (bus.req_a)
                                state_next = ST_GNT_A;
                            else if (bus.req_b)
                                state_next = ST_GNT_B;
                            else
                                state_next = ST_IDLE;
                        end
                    endcase
                end
                MODE_FORCE_A: state_next = bus.req_a ? ST_GNT_A : ST_IDLE;
                MODE_FORCE_B: state_next = bus.req_b ? ST_GNT_B : ST_IDLE;
                default:      state_next = ST_LAMP;
            endcase
        end
    end

    assign entry_a = (state_next == ST_GNT_A) && (state != ST_GNT_A);
    assign entry_b = (state_next == ST_GNT_B) && (state != ST_GNT_B);

    // Stage: arbiter registers. Grants are decoded straight from the state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state   <= ST_IDLE;
            dwell   <= '0;
            a_first <= 1'b1;
        end else begin
            state <= state_next;
            if (entry_a || entry_b || (state_next == ST_IDLE) || (state_next == ST_LAMP))
                dwell <= '0;
            else if (!dwell_done)
                dwell <= dwell + DW_W'(1);
            if (entry_a)
                a_first <= 1'b0;
            else if (entry_b)
                a_first <= 1'b1;
        end
    end

    assign bus.grant_a = (state == ST_GNT_A);
    assign bus.grant_b = (state == ST_GNT_B);

    always_comb begin
        sel_data = bus.data_a;
        sel_dp   = bus.dp_a;
        sel_led  = bus.led_a;
        if (state == ST_GNT_B) begin
            sel_data = bus.data_b;
            sel_dp   = bus.dp_b;
            sel_led  = bus.led_b;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_digit
        hex_to_sseg u_hex (
            .nibble (sel_data[4*i +: 4]),
            .dp     (sel_dp[i]),
            .seg    (seg_dec[i])
        );
    end

    // Stage: registered pin drive, one cycle behind the grant.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 4; i++) sseg_p2[i] <= SEG_BLANK;
            led_p2 <= LED_OFF;
        end else begin
            case (state)
                ST_GNT_A, ST_GNT_B: begin
                    for (int i = 0; i < 4; i++) sseg_p2[i] <= seg_dec[i];
                    led_p2 <= sel_led;
                end
                ST_LAMP: begin
                    for (int i = 0; i < 4; i++) sseg_p2[i] <= SEG_LAMP;
                    led_p2 <= LED_LAMP;
                end
                default: begin
                    for (int i = 0; i < 4; i++) sseg_p2[i] <= SEG_BLANK;
                    led_p2 <= LED_OFF;
                end
            endcase
        end
    end

    assign bus.sseg0   = sseg_p2[0];
    assign bus.sseg1   = sseg_p2[1];
    assign bus.sseg2   = sseg_p2[2];
    assign bus.sseg3   = sseg_p2[3];
    assign bus.led_out = led_p2;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed bench for sseg_display_arbiter with short dwell and debounce times.
module tb_sseg_display_arbiter;

    logic       clk_clk;
    logic       reset_reset_n;
    logic [1:0] switch_in;
    int         n_tests;
    int         n_fail;

    sseg_display_arbiter_if bus ();

    sseg_display_arbiter #(
        .DWELL_CYCLES    (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .switch_in     (switch_in),
        .bus           (bus)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        switch_in     = 2'b00;
        reset_reset_n = 1'b0;
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b0;
        bus.data_a = 16'h1234;
        bus.data_b = 16'h9ABC;
        bus.dp_a   = 4'b0000;
        bus.dp_b   = 4'b0000;
        bus.led_a  = 8'hA5;
        bus.led_b  = 8'h3C;

        // Reset held with a pending request
        tick(); tick();
        check_eq("rst_sseg0", bus.sseg0, 16'hFF);
        check_eq("rst_sseg3", bus.sseg3, 16'hFF);
        check_eq("rst_led", bus.led_out, 16'h00);
        check_eq("rst_grant_a", bus.grant_a, 1'b0);
        check_eq("rst_grant_b", bus.grant_b, 1'b0);

        reset_reset_n = 1'b1;
        tick();
        check_eq("first_grant_a", bus.grant_a, 1'b1);
        check_eq("first_sseg_lag", bus.sseg0, 16'hFF);
        tick();
        check_eq("dig0_4", bus.sseg0, 16'h99);
        check_eq("dig1_3", bus.sseg1, 16'hB0);
        check_eq("dig2_2", bus.sseg2, 16'hA4);
        check_eq("dig3_1", bus.sseg3, 16'hF9);
        check_eq("led_a", bus.led_out, 16'hA5);

        bus.data_a = 16'hF800;
        bus.dp_a   = 4'b1000;
        tick();
        check_eq("dig0_0", bus.sseg0, 16'hC0);
        check_eq("dig2_8", bus.sseg2, 16'h80);
        check_eq("dig3_F_dp", bus.sseg3, 16'h0E);

        bus.req_a = 1'b0;
        tick();
        check_eq("drop_grant_a", bus.grant_a, 1'b0);
        check_eq("drop_sseg_lag", bus.sseg3, 16'h0E);
        tick();
        check_eq("drop_blank", bus.sseg3, 16'hFF);
        check_eq("drop_led", bus.led_out, 16'h00);

        // Fresh reset so the round-robin pointer favours A again
        reset_reset_n = 1'b0;
        tick();
        reset_reset_n = 1'b1;
        tick();
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        tick();
        check_eq("both_grant_a", bus.grant_a, 1'b1);
        check_eq("both_grant_b", bus.grant_b, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("dwell_a", bus.grant_a, 1'b1);
        end
        tick();
        check_eq("switch_to_b", bus.grant_b, 1'b1);
        check_eq("switch_a_off", bus.grant_a, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("dwell_b", bus.grant_b, 1'b1);
            if (i == 0) check_eq("led_b", bus.led_out, 16'h3C);
        end
        tick();
        check_eq("back_to_a", bus.grant_a, 1'b1);
        check_eq("back_b_off", bus.grant_b, 1'b0);

        // Own request drops early in the dwell
        tick(); tick();
        bus.req_a = 1'b0;
        tick();
        check_eq("early_drop_a", bus.grant_a, 1'b0);
        check_eq("early_drop_b", bus.grant_b, 1'b0);
        tick();
        check_eq("pending_b", bus.grant_b, 1'b1);

        // Two-cycle bounce toward FORCE_B must not change mode
        switch_in = 2'b10;
        tick(); tick();
        switch_in = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("bounce_hold", bus.grant_b, 1'b1);
        end

        // Stable FORCE_B
        switch_in = 2'b10;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("pre_mode_b", bus.grant_b, 1'b1);
        end
        tick();
        check_eq("mode_idle_b", bus.grant_b, 1'b0);
        tick();
        check_eq("force_b_grant", bus.grant_b, 1'b1);
        bus.req_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("force_b_no_a", bus.grant_a, 1'b0);
            check_eq("force_b_hold", bus.grant_b, 1'b1);
        end
        bus.req_b = 1'b0;
        tick();
        check_eq("force_b_drop", bus.grant_b, 1'b0);
        tick();
        check_eq("force_b_a_blocked", bus.grant_a, 1'b0);

        // Lamp test
        switch_in = 2'b11;
        for (int i = 0; i < 8; i++) tick();
        check_eq("lamp_grant_a", bus.grant_a, 1'b0);
        check_eq("lamp_grant_b", bus.grant_b, 1'b0);
        tick();
        check_eq("lamp_sseg0", bus.sseg0, 16'h00);
        check_eq("lamp_sseg1", bus.sseg1, 16'h00);
        check_eq("lamp_sseg2", bus.sseg2, 16'h00);
        check_eq("lamp_sseg3", bus.sseg3, 16'h00);
        check_eq("lamp_led", bus.led_out, 16'hFF);

        // Back to AUTO with A requesting
        switch_in = 2'b00;
        for (int i = 0; i < 7; i++) tick();
        check_eq("unlamp_idle", bus.grant_a, 1'b0);
        check_eq("unlamp_led_lag", bus.led_out, 16'hFF);
        tick();
        check_eq("auto_grant_a", bus.grant_a, 1'b1);
        check_eq("auto_led_blank", bus.led_out, 16'h00);
        check_eq("auto_sseg_blank", bus.sseg0, 16'hFF);
        tick();
        check_eq("auto_dig3", bus.sseg3, 16'h0E);
        check_eq("auto_led_a", bus.led_out, 16'hA5);

        // Asynchronous reset between clock edges
        #2;
        reset_reset_n = 1'b0;
        #1;
        check_eq("async_grant_a", bus.grant_a, 1'b0);
        check_eq("async_sseg3", bus.sseg3, 16'hFF);
        check_eq("async_led", bus.led_out, 16'h00);
        tick();
        reset_reset_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
